// File: rtl/pixel_shader.sv
// Flat Lambert shader: face normal by cross product, squared cosine against a fixed
// light vector, restoring long division to a COLOR_W-bit greyscale intensity.
module pixel_shader #(
  parameter logic signed [7:0] LX      = 8'sd0,
  parameter logic signed [7:0] LY      = 8'sd1,
  parameter logic signed [7:0] LZ      = 8'sd0,
  parameter int unsigned       COLOR_W = 8
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      data_valid_in,
  input  logic [3:0][2:0][31:0]     triangle,
  output logic                      valid_out,
  output logic [COLOR_W-1:0]        color_out
);

  localparam int unsigned LL = unsigned'(int'(LX) * int'(LX) + int'(LY) * int'(LY)
                                         + int'(LZ) * int'(LZ));
  localparam int unsigned CNT_W = $clog2(COLOR_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_EDGE, S_CROSS, S_DOT, S_SQUARE, S_DIV, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [2:0][2:0][15:0] r_v;
  logic [2:0][16:0]      r_e1, r_e2;
  logic signed [34:0]    r_nx, r_ny, r_nz;
  logic signed [44:0]    r_d;
  logic [71:0]           r_nn;
  logic [95:0]           r_num, r_den;
  logic [96:0]           r_rem;
  logic [COLOR_W-1:0]    r_q;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_busy;
  logic signed [16:0]    w_e1 [3];
  logic signed [16:0]    w_e2 [3];
  logic [44:0]           w_dmag;
  logic [95:0]           w_num;
  logic [96:0]           w_sh;
  logic                  w_ge;
  logic                  w_unused;

  assign w_busy = (r_state != S_IDLE);

  always_comb begin
    w_unused = ^triangle[3];
    for (int unsigned v = 0; v < 3; v++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        w_unused = w_unused ^ (^triangle[v][c][31:16]);
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < 3; c++) begin
      w_e1[c] = $signed(r_e1[c]);
      w_e2[c] = $signed(r_e2[c]);
    end
  end

  // Backface, perpendicular and degenerate triangles all collapse to a zero numerator.
  assign w_dmag = r_d;
  assign w_num  = (r_d <= 45'sd0 || r_nn == '0) ? '0 : 96'(w_dmag) * 96'(w_dmag);
  assign w_sh   = {r_rem[95:0], 1'b0};
  assign w_ge   = (w_sh >= {1'b0, r_den});

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (data_valid_in && !w_busy) w_next = S_EDGE;
      S_EDGE:   w_next = S_CROSS;
      S_CROSS:  w_next = S_DOT;
      S_DOT:    w_next = S_SQUARE;
      S_SQUARE: w_next = S_DIV;
      S_DIV:    if (r_cnt == CNT_W'(COLOR_W - 1)) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_v       <= '0;
      r_e1      <= '0;
      r_e2      <= '0;
      r_nx      <= '0;
      r_ny      <= '0;
      r_nz      <= '0;
      r_d       <= '0;
      r_nn      <= '0;
      r_num     <= '0;
      r_den     <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      valid_out <= 1'b0;
      color_out <= '0;
    end else begin
      valid_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (data_valid_in) begin
            for (int unsigned v = 0; v < 3; v++) begin
              for (int unsigned c = 0; c < 3; c++) begin
                r_v[v][c] <= triangle[v][c][15:0];
              end
            end
          end
        end
        S_EDGE: begin
          for (int unsigned c = 0; c < 3; c++) begin
            r_e1[c] <= 17'($signed(r_v[1][c])) - 17'($signed(r_v[0][c]));
            r_e2[c] <= 17'($signed(r_v[2][c])) - 17'($signed(r_v[0][c]));
          end
        end
        S_CROSS: begin
          r_nx <= 35'(w_e1[1]) * 35'(w_e2[2]) - 35'(w_e1[2]) * 35'(w_e2[1]);
          r_ny <= 35'(w_e1[2]) * 35'(w_e2[0]) - 35'(w_e1[0]) * 35'(w_e2[2]);
          r_nz <= 35'(w_e1[0]) * 35'(w_e2[1]) - 35'(w_e1[1]) * 35'(w_e2[0]);
        end
        S_DOT: begin
          r_d  <= 45'(r_nx) * 45'(LX) + 45'(r_ny) * 45'(LY) + 45'(r_nz) * 45'(LZ);
          r_nn <= 72'(r_nx) * 72'(r_nx) + 72'(r_ny) * 72'(r_ny) + 72'(r_nz) * 72'(r_nz);
        end
        S_SQUARE: begin
          r_num <= w_num;
          r_den <= 96'(r_nn) * 96'(LL);
          r_rem <= {1'b0, w_num};
          r_q   <= '0;
          r_cnt <= '0;
        end
        S_DIV: begin
          r_rem <= w_ge ? (w_sh - {1'b0, r_den}) : w_sh;
          r_q   <= (r_q << 1) | COLOR_W'(w_ge);
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DONE: begin
          // Zero denominator would otherwise divide to all-ones; aligned case saturates.
          if (r_den == '0)         color_out <= '0;
          else if (r_num == r_den) color_out <= '1;
          else                     color_out <= r_q;
          valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_shader.sv
// Randomised and directed bench for pixel_shader, two light settings checked against
// a wide-integer arithmetic reference model.
module tb_pixel_shader;

  typedef logic [2:0][2:0][15:0] tri_t;
  typedef logic signed [127:0]   big_t;

  logic                  clk_in;
  logic                  rst_in;
  logic                  data_valid_in;
  logic [3:0][2:0][31:0] triangle;
  logic                  valid_out, valid_out2;
  logic [7:0]            color_out, color_out2;

  int checks   = 0;
  int failures = 0;

  pixel_shader dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_valid_in (data_valid_in),
    .triangle      (triangle),
    .valid_out     (valid_out),
    .color_out     (color_out)
  );

  pixel_shader #(.LX(8'sd3), .LY(-8'sd2), .LZ(8'sd5), .COLOR_W(8)) dut2 (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_valid_in (data_valid_in),
    .triangle      (triangle),
    .valid_out     (valid_out2),
    .color_out     (color_out2)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input tri_t t, input int lx, input int ly, input int lz);
    longint a[3], b[3], n[3];
    big_t d, nn, ll, num, den, q;
    for (int c = 0; c < 3; c++) begin
      a[c] = longint'($signed(t[1][c])) - longint'($signed(t[0][c]));
      b[c] = longint'($signed(t[2][c])) - longint'($signed(t[0][c]));
    end
    n[0] = a[1] * b[2] - a[2] * b[1];
    n[1] = a[2] * b[0] - a[0] * b[2];
    n[2] = a[0] * b[1] - a[1] * b[0];
    d  = big_t'(n[0]) * big_t'(lx) + big_t'(n[1]) * big_t'(ly) + big_t'(n[2]) * big_t'(lz);
    nn = big_t'(n[0]) * big_t'(n[0]) + big_t'(n[1]) * big_t'(n[1]) + big_t'(n[2]) * big_t'(n[2]);
    ll = big_t'(lx * lx + ly * ly + lz * lz);
    num = (d > 0 && nn != 0) ? d * d : big_t'(0);
    den = nn * ll;
    if (den == 0) return 8'd0;
    if (num == den) return 8'hFF;
    q = (num * 256) / den;
    return q[7:0];
  endfunction

  function automatic tri_t mk(input int x0, y0, z0, x1, y1, z1, x2, y2, z2);
    tri_t t;
    t[0][0] = 16'(x0); t[0][1] = 16'(y0); t[0][2] = 16'(z0);
    t[1][0] = 16'(x1); t[1][1] = 16'(y1); t[1][2] = 16'(z1);
    t[2][0] = 16'(x2); t[2][1] = 16'(y2); t[2][2] = 16'(z2);
    return t;
  endfunction

  // Upper word bits and the reserved vertex carry junk so the DUT must ignore them.
  task automatic drive_tri(input tri_t t);
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 3; c++)
        triangle[v][c] = {16'($urandom), t[v][c]};
    triangle[3] = {$urandom, $urandom, $urandom};
  endtask

  task automatic run_tri(input tri_t t, input string tag, input bit busy_strobe,
                         input tri_t intruder);
    logic [7:0] e1, e2, c1, c2;
    int seen1, seen2, p1, p2;
    e1 = model(t, 0, 1, 0);
    e2 = model(t, 3, -2, 5);
    seen1 = -1; seen2 = -1; p1 = 0; p2 = 0; c1 = '0; c2 = '0;
    @(negedge clk_in);
    drive_tri(t);
    data_valid_in = 1'b1;
    @(posedge clk_in);
    #1 data_valid_in = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (busy_strobe && (k == 3 || k == 9)) begin
        drive_tri(intruder);
        data_valid_in = 1'b1;
      end
      @(posedge clk_in);
      #1 data_valid_in = 1'b0;
      if (valid_out)  begin p1++; if (seen1 < 0) seen1 = k; end
      if (valid_out2) begin p2++; if (seen2 < 0) seen2 = k; end
      if (k == 13) begin c1 = color_out; c2 = color_out2; end
    end
    chk({tag, ".lat"}, seen1, 13);
    chk({tag, ".pulses"}, p1, 1);
    chk({tag, ".color"}, c1, e1);
    chk({tag, ".hold"}, color_out, e1);
    chk({tag, ".lat2"}, seen2, 13);
    chk({tag, ".pulses2"}, p2, 1);
    chk({tag, ".color2"}, c2, e2);
  endtask

  task automatic run_abort(input tri_t t);
    int p;
    p = 0;
    @(negedge clk_in);
    drive_tri(t);
    data_valid_in = 1'b1;
    @(posedge clk_in);
    #1 data_valid_in = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk_in);
      #1;
      if (valid_out || valid_out2) p++;
      if (k == 6) begin
        rst_in = 1'b0;
        #1;
        chk("abort.color", color_out, 0);
        chk("abort.valid", valid_out, 0);
        chk("abort.color2", color_out2, 0);
      end
      if (k == 8) rst_in = 1'b1;
    end
    chk("abort.pulses", p, 0);
  endtask

  initial begin
    tri_t c1, c2, c3, c4, c5, rt;
    bit   big;
    rst_in = 1'b0;
    data_valid_in = 1'b0;
    triangle = '0;
    c1 = mk(7, 21, 30, 7, 23, 30, 9, 21, 32);
    c2 = mk(0, 0, 0, 0, 0, 1, 1, 0, 0);
    c3 = mk(0, 0, 0, 1, 0, 0, 0, 0, 1);
    c4 = mk(0, 0, 0, 0, 0, 1, 1, 1, 0);
    c5 = mk(0, 0, 0, 1, 1, 1, 2, 2, 2);
    repeat (3) @(posedge clk_in);
    #1;
    chk("reset.valid", valid_out, 0);
    chk("reset.color", color_out, 0);
    chk("reset.color2", color_out2, 0);
    @(negedge clk_in);
    rst_in = 1'b1;

    chk("model.c4", model(c4, 0, 1, 0), 128);
    run_tri(c1, "case1", 1'b0, c1);
    run_tri(c2, "case2", 1'b0, c2);
    run_tri(c3, "case3", 1'b0, c3);
    run_tri(c4, "case4", 1'b0, c4);
    run_tri(c5, "case5", 1'b1, c2);
    run_tri(c4, "case4b", 1'b0, c4);
    run_abort(c2);
    run_tri(c4, "case6", 1'b0, c4);

    for (int i = 0; i < 40; i++) begin
      big = ($urandom_range(0, 2) == 0);
      for (int v = 0; v < 3; v++)
        for (int c = 0; c < 3; c++)
          rt[v][c] = big ? 16'($urandom) : 16'($urandom_range(0, 16) - 8);
      run_tri(rt, $sformatf("rnd%0d", i), ($urandom_range(0, 3) == 0), c2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
